// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths, word type, read-latency bound, skid sizing helper.
// Combinational constants only; no latency, no backpressure.
package fifo_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 4;
   localparam int MAX_RD_LATENCY     = 2;

   typedef logic [DEFAULT_DATA_WIDTH-1:0] fifo_word_t;

   // One entry per in-flight read plus one so reads keep flowing while the head is being popped.
   function automatic int skid_depth(input int rd_latency);
      return rd_latency + 1;
   endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready word stream leaving the FIFO read stage.
// Wires only; master holds valid/data stable until ready.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
) ();
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_skid_buf.sv
// Circular skid buffer of DEPTH words; head is read straight from registered storage.
// Push lands in one cycle; the owner guarantees no push when full, flush empties it.
module fifo_skid_buf #(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = 8,
   parameter int CW         = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CW-1:0]         count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= push_data;
            wptr      <= nxt(wptr);
         end
         if (pop) rptr <= nxt(rptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   assign head = mem[rptr];
endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read drain: issues reads, absorbs RD_LATENCY in a skid buffer, emits a valid/ready stream.
// First word visible RD_LATENCY cycles after its read; reads stop when buffered + in-flight words fill the skid.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_rd,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   fifo_rd_stream_if.master      m,
   output logic [CNT_WIDTH-1:0]  word_cnt
);
   localparam int SKID_DEPTH = skid_depth(RD_LATENCY);
   localparam int CW         = $clog2(skid_depth(MAX_RD_LATENCY) + 1);

   logic [RD_LATENCY-1:0] pipe;
   logic [CW-1:0]         skid_count;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         discard;
   logic [CW:0]           used;
   logic                  tail;
   logic                  pop;
   logic                  push;

   assign tail = pipe[RD_LATENCY-1];
   assign pop  = m.valid & m.ready;
   assign push = tail & (discard == '0);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
   end

   // Credits count the slot freed by this cycle's pop so a streaming consumer sees one word per cycle.
   assign used = {1'b0, skid_count} - {{CW{1'b0}}, pop} + {1'b0, inflight} + {1'b0, discard};

   assign fifo_rd_en = ~fifo_empty & ~flush & ~rst & (used < (CW + 1)'(SKID_DEPTH));

   always_ff @(posedge clk_rd) begin
      if (rst) begin
         pipe     <= '0;
         discard  <= '0;
         word_cnt <= '0;
      end else begin
         pipe <= (pipe << 1) | RD_LATENCY'(fifo_rd_en);
         // A word arriving on the flush edge is already lost with the buffer, so it is not counted.
         if (flush)                    discard <= inflight - CW'(tail);
         else if (tail && discard != '0) discard <= discard - 1'b1;
         if (pop) word_cnt <= word_cnt + 1'b1;
      end
   end

   fifo_skid_buf #(
      .DEPTH      (SKID_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CW         (CW)
   ) u_skid (
      .clk        (clk_rd),
      .rst        (rst),
      .flush      (flush),
      .push       (push),
      .push_data  (fifo_data),
      .pop        (pop),
      .head       (m.data),
      .count      (skid_count)
   );

   assign m.valid = (skid_count != '0);
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Three lanes (lat1/cnt16, lat1/cnt4, lat2/cnt4) share stimulus; each has its own FIFO and word-order model.
module tb_fifo_rd_stream;
   import fifo_pkg::*;

   localparam int NL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, m_ready, force_empty;
   logic        lane_empty [NL];
   logic [7:0]  lane_fdata [NL];
   logic        lane_rd_en [NL];
   logic        lane_valid [NL];
   logic [7:0]  lane_data  [NL];
   logic [15:0] lane_cnt   [NL];

   for (genvar g = 0; g < NL; g++) begin : gl
      localparam int L   = (g == 2) ? 2 : 1;
      localparam int CWD = (g == 0) ? 16 : 4;
      logic [CWD-1:0] cnt;
      fifo_rd_stream_if #(.DATA_WIDTH(8)) s ();
      fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(L), .CNT_WIDTH(CWD)) dut (
         .clk_rd     (clk),
         .rst        (rst),
         .flush      (flush),
         .fifo_empty (lane_empty[g]),
         .fifo_rd_en (lane_rd_en[g]),
         .fifo_data  (lane_fdata[g]),
         .m          (s),
         .word_cnt   (cnt)
      );
      assign s.ready       = m_ready;
      assign lane_valid[g] = s.valid;
      assign lane_data[g]  = s.data;
      assign lane_cnt[g]   = 16'(cnt);
   end

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   logic [7:0] fmem [NL][256];
   int         fhead [NL];
   int         ftail [NL];
   logic [7:0] dl0 [NL];
   logic [7:0] dl1 [NL];
   logic [7:0] od [NL][256];
   int         oe [NL][256];
   int         oh [NL];
   int         ot [NL];
   int         exp_cnt [NL];
   int         reads_seen [NL];
   logic [7:0] plog [NL][64];
   int         pn [NL];
   int         first_pop [NL];
   int         last_pop [NL];

   function automatic int lat_of(input int l);
      return (l == 2) ? 2 : 1;
   endfunction

   function automatic int cnt_mask(input int l);
      return (l == 0) ? 32'hFFFF : 32'hF;
   endfunction

   task automatic chk(input string name, input int ln, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s lane%0d: got %0h expected %0h (t=%0t)", name, ln, act, exp, $time);
      end
   endtask

   task automatic drive_in();
      for (int l = 0; l < NL; l++) begin
         lane_empty[l] = force_empty || (fhead[l] == ftail[l]);
         lane_fdata[l] = (lat_of(l) == 2) ? dl1[l] : dl0[l];
      end
   endtask

   task automatic tick();
      bit         rd [NL];
      bit         pp [NL];
      bit         vis;
      logic [7:0] w;
      drive_in();
      #2;
      for (int l = 0; l < NL; l++) begin
         vis = (oh[l] != ot[l]) && (oe[l][oh[l] % 256] + lat_of(l) <= edge_n);
         chk("m_valid", l, lane_valid[l], vis);
         if (vis && lane_valid[l]) chk("m_data", l, lane_data[l], od[l][oh[l] % 256]);
         chk("word_cnt", l, lane_cnt[l], exp_cnt[l]);
         if (lane_rd_en[l]) chk("rd_en_legal", l, lane_empty[l] | rst | flush, 0);
         rd[l] = lane_rd_en[l] && !lane_empty[l];
         pp[l] = vis && m_ready;
      end
      @(posedge clk);
      edge_n++;
      #1;
      for (int l = 0; l < NL; l++) begin
         w = fmem[l][fhead[l] % 256];
         if (rst) begin
            oh[l]      = ot[l];
            exp_cnt[l] = 0;
         end else begin
            if (pp[l]) begin
               if (pn[l] < 64) plog[l][pn[l]] = od[l][oh[l] % 256];
               if (pn[l] == 0) first_pop[l] = edge_n;
               last_pop[l] = edge_n;
               pn[l]++;
               oh[l]++;
               exp_cnt[l] = (exp_cnt[l] + 1) & cnt_mask(l);
            end
            if (flush) oh[l] = ot[l];
            if (rd[l]) begin
               od[l][ot[l] % 256] = w;
               oe[l][ot[l] % 256] = edge_n;
               ot[l]++;
               reads_seen[l]++;
            end
            chk("credit", l, (ot[l] - oh[l]) <= lat_of(l) + 1, 1);
         end
         dl1[l] = dl0[l];
         if (rd[l]) begin
            dl0[l] = w;
            fhead[l]++;
         end else begin
            dl0[l] = 8'($urandom);
         end
      end
   endtask

   task automatic load_seq(input int base, input int n, input bit rnd);
      for (int l = 0; l < NL; l++) begin
         fhead[l] = 0;
         ftail[l] = n;
         for (int i = 0; i < n; i++) fmem[l][i] = rnd ? 8'($urandom) : 8'(base + i);
      end
   endtask

   task automatic clear_logs();
      for (int l = 0; l < NL; l++) begin
         pn[l] = 0;
         reads_seen[l] = 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      clear_logs();
   endtask

   function automatic bit busy();
      bit b = 1'b0;
      for (int l = 0; l < NL; l++) if (fhead[l] != ftail[l] || oh[l] != ot[l]) b = 1'b1;
      return b;
   endfunction

   task automatic drain(input int budget);
      int n = 0;
      force_empty = 1'b0; flush = 1'b0; rst = 1'b0; m_ready = 1'b1;
      while (busy() && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 0, busy(), 0);
   endtask

   task automatic chk_seq(input string name, input int l, input int base, input int n);
      bit ok = (pn[l] == n);
      for (int i = 0; i < n && i < 64; i++) if (plog[l][i] != 8'(base + i)) ok = 1'b0;
      chk(name, l, ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      int e_start;
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
      for (int l = 0; l < NL; l++) begin
         dl0[l] = '0; dl1[l] = '0; oh[l] = 0; ot[l] = 0; exp_cnt[l] = 0;
         first_pop[l] = 0; last_pop[l] = 0;
      end
      clear_logs();
      load_seq(1, 16, 1'b0);
      drive_in();
      @(posedge clk);
      #1;

      // Reset holds everything idle even with a non-empty FIFO.
      tick();
      tick();
      for (int l = 0; l < NL; l++) begin
         chk("rst_rd_en", l, lane_rd_en[l], 0);
         chk("rst_m_valid", l, lane_valid[l], 0);
         chk("rst_m_data", l, lane_data[l], 0);
         chk("rst_word_cnt", l, lane_cnt[l], 0);
      end
      rst = 1'b0;
      clear_logs();

      // Streaming 0x01..0x10 with constant ready.
      e_start = edge_n + 1;
      drain(80);
      chk("stream_cnt", 0, lane_cnt[0], 16);
      chk("stream_cnt", 1, lane_cnt[1], 0);
      chk("stream_cnt", 2, lane_cnt[2], 0);
      for (int l = 0; l < NL; l++) begin
         chk_seq("stream_order", l, 1, 16);
         chk("stream_rate", l, last_pop[l] - first_pop[l], 15);
         chk("stream_latency", l, first_pop[l] - e_start, lat_of(l) + 1);
         chk("stream_idle", l, lane_valid[l], 0);
      end

      // Back-pressure: reads stop once the skid is committed, head word held.
      load_seq(1, 16, 1'b0);
      do_reset();
      repeat (10) tick();
      for (int l = 0; l < NL; l++) begin
         chk("bp_reads", l, reads_seen[l], lat_of(l) + 1);
         chk("bp_valid", l, lane_valid[l], 1);
         chk("bp_hold", l, lane_data[l], 8'h01);
      end
      drain(100);
      for (int l = 0; l < NL; l++) chk_seq("bp_order", l, 1, 16);

      // Empty flag toggling every cycle with random ready.
      load_seq(0, 16, 1'b1);
      do_reset();
      for (int i = 0; i < 60; i++) begin
         force_empty = ~force_empty;
         m_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain(100);
      for (int l = 0; l < NL; l++) chk("toggle_count", l, pn[l], 16);

      // Flush with one word buffered and one in flight.
      load_seq(8'hA0, 8, 1'b0);
      do_reset();
      tick();
      force_empty = 1'b1;
      tick();
      force_empty = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int l = 0; l < NL; l++) begin
         chk("flush_valid", l, lane_valid[l], 0);
         chk("flush_reads", l, reads_seen[l], 2);
      end
      drain(100);
      for (int l = 0; l < NL; l++) begin
         chk("flush_first", l, plog[l][0], 8'hA2);
         chk("flush_count", l, pn[l], 6);
      end

      // Counter wrap at 4 bits, both latencies.
      load_seq(8'h30, 17, 1'b0);
      do_reset();
      drain(100);
      chk("wrap_cnt", 0, lane_cnt[0], 17);
      chk("wrap_cnt", 1, lane_cnt[1], 1);
      chk("wrap_cnt", 2, lane_cnt[2], 1);
      for (int l = 0; l < NL; l++) chk_seq("wrap_order", l, 8'h30, 17);

      // Random traffic with sporadic flush and reset.
      load_seq(0, 8, 1'b1);
      do_reset();
      for (int i = 0; i < 500; i++) begin
         m_ready     = ($urandom_range(0, 3) != 0);
         force_empty = ($urandom_range(0, 3) == 0);
         flush       = ($urandom_range(0, 29) == 0);
         rst         = ($urandom_range(0, 79) == 0);
         for (int l = 0; l < NL; l++) begin
            if (ftail[l] - fhead[l] < 4) begin
               fmem[l][ftail[l] % 256] = 8'($urandom);
               ftail[l]++;
            end
         end
         tick();
      end
      drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
